dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the single-port data_memory.
- Port 0 serves the pipeline MEM stage; port 1 serves the program/data loader and debug access.
- Serialises requests into one-cycle memory accesses, registers read data, returns a one-cycle ack per transaction.
- Rejects out-of-range word addresses without touching memory.

Parameters:
ADDR_W, 64, width of address buses (word index, directly indexes memory[])
DATA_W, 64, width of data buses
MEM_WORDS, 1024, number of 64-bit words in data_memory; valid addresses 0..MEM_WORDS-1

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
p0_req  input  1  port 0 request; held high until p0_ack
p0_we  input  1  port 0 write enable (1 = write, 0 = read); stable while p0_req
p0_addr  input  ADDR_W  port 0 word address; stable while p0_req
p0_wdata  input  DATA_W  port 0 write data; stable while p0_req
p0_ack  output  1  one-cycle completion pulse for port 0
p0_rdata  output  DATA_W  port 0 read data, valid when p0_ack
p0_err  output  1  address out of range, valid when p0_ack
p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata, p1_err  same as port 0, for port 1
mem_write  output  1  to data_memory mem_write
mem_read  output  1  to data_memory mem_read
mem_address  output  ADDR_W  to data_memory address
mem_write_data  output  DATA_W  to data_memory write_data
mem_read_data  input  DATA_W  from data_memory read_data (combinational read)
busy  output  1  high in any state other than IDLE

Behaviour:
- State machine: IDLE, ACCESS, RESP. Registers: state, gnt (granted port), lat_we, lat_addr, lat_wdata, rdata_q, err_q, last_gnt.
- Reset (synchronous, sampled at the rising edge):
  - state=IDLE; last_gnt=1, so port 0 wins the first tie.
  - All acks, errs and rdata regs cleared to 0.
  - mem_write=mem_read=0, mem_address=0, mem_write_data=0, busy=0.
- IDLE, no request: remain in IDLE.
- IDLE, one request: grant that port.
- IDLE, both requesting: grant the port != last_gnt.
- On grant:
  - Latch the granted port's we/addr/wdata.
  - If addr >= MEM_WORDS: err_q=1, rdata_q=0, go to RESP with no memory access.
  - Otherwise err_q=0, go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_address=lat_addr.
  - Write (lat_we=1): mem_write=1, mem_write_data=lat_wdata; the write commits at the closing edge.
  - Read (lat_we=0): mem_read=1.
  - At the closing edge: rdata_q = mem_read_data for a read, 0 for a write. Go to RESP.
- Memory outputs outside ACCESS: mem_write=0, mem_read=0, mem_address=0, mem_write_data=0. They are decoded from registered state, so they carry no glitch paths from the request inputs.
- RESP (one cycle):
  - Assert pX_ack=1 for granted port X only; pX_rdata=rdata_q, pX_err=err_q.
  - The other port's ack=0 and rdata=0.
  - last_gnt=gnt at the closing edge; return to IDLE.
- ack, rdata and err are 0 in every cycle where ack is low.
- Latency:
  - req high in IDLE cycle N: ACCESS in N+1, ack in N+2.
  - Out-of-range: ack in N+1.
  - Steady throughput: one transaction per 3 cycles.
- Requester protocol:
  - Deassert req the cycle after ack, or keep it high to issue a new transaction.
  - A req still high in IDLE is treated as a new request.
  - Inputs change only after ack; changes during ACCESS/RESP are ignored because values are latched.
- Fairness: with both ports continuously requesting, grants strictly alternate; no port waits more than one transaction.
- Reset mid-operation:
  - Reset sampled during ACCESS: the write still commits at that edge, since memory samples the same edge. No ack is issued and the state is IDLE next cycle.
  - Reset during RESP: the ack that cycle is still visible; state and last_gnt are reset.
- Address width: the full ADDR_W comparison against MEM_WORDS; no truncation or wrap-around.

Test Plan:
- Reset 2 cycles, then p0 write addr 10 data 0xDEADBEEFDEADBEEF -> mem_write high exactly 1 cycle; p0_ack 2 cycles after req; memory[10]=0xDEADBEEFDEADBEEF; p0_err=0; p0_rdata=0.
- p1 read addr 10 -> mem_read high 1 cycle; p1_ack with p1_rdata=0xDEADBEEFDEADBEEF; p0_ack stays 0.
- p0 write addr 2 = 0xCAFEBABECAFEBABE and p1 read addr 2 raised in the same cycle after reset -> p0 served first; p1 then reads 0xCAFEBABECAFEBABE; acks 3 cycles apart.
- Both ports held requesting for 6 transactions -> grant order 0,1,0,1,0,1; busy stays high except the IDLE cycles.
- p0 read addr 2000 (MEM_WORDS=1024) -> p0_ack 1 cycle after req with p0_err=1, p0_rdata=0; mem_read and mem_write never asserted.
- Assert reset in the ACCESS cycle of a p1 write to addr 5 = 0x1234 -> memory[5]=0x1234; no p1_ack; busy=0 and all outputs 0 the next cycle.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Requester ports and data_memory bus of the two-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_err;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_err;

    logic              mem_write;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    // Requesters and the memory model sit on the master side.
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_ack, p0_rdata, p0_err,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ack, p1_rdata, p1_err,
        input  mem_write, mem_read, mem_address, mem_write_data,
        output mem_read_data
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_ack, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ack, p1_rdata, p1_err,
        output mem_write, mem_read, mem_address, mem_write_data,
        input  mem_read_data
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin two-port arbiter/sequencer for single-port memory.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_WORDS = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_arbiter_if.slave        bus,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    // Range check is done one bit wider than either operand so nothing wraps.
    localparam int               CMP_W       = ((ADDR_W > 32) ? ADDR_W : 32) + 1;
    localparam logic [CMP_W-1:0] C_MEM_WORDS = CMP_W'(MEM_WORDS);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_gnt;
    logic              r_last_gnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_any;
    logic              w_sel;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_oor;

    assign w_any       = bus.p0_req | bus.p1_req;
    assign w_sel       = (bus.p0_req & bus.p1_req) ? ~r_last_gnt : ~bus.p0_req;
    assign w_sel_we    = w_sel ? bus.p1_we    : bus.p0_we;
    assign w_sel_addr  = w_sel ? bus.p1_addr  : bus.p0_addr;
    assign w_sel_wdata = w_sel ? bus.p1_wdata : bus.p0_wdata;
    assign w_oor       = CMP_W'(w_sel_addr) >= C_MEM_WORDS;

    always_comb begin
        w_state_nxt        = r_state;
        bus.mem_write      = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_address    = '0;
        bus.mem_write_data = '0;
        bus.p0_ack         = 1'b0;
        bus.p0_rdata       = '0;
        bus.p0_err         = 1'b0;
        bus.p1_ack         = 1'b0;
        bus.p1_rdata       = '0;
        bus.p1_err         = 1'b0;
        busy               = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_any) w_state_nxt = w_oor ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                w_state_nxt        = S_RESP;
                bus.mem_address    = r_addr;
                bus.mem_write      = r_we;
                bus.mem_read       = ~r_we;
                bus.mem_write_data = r_we ? r_wdata : '0;
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                if (r_gnt) begin
                    bus.p1_ack   = 1'b1;
                    bus.p1_rdata = r_rdata;
                    bus.p1_err   = r_err;
                end else begin
                    bus.p0_ack   = 1'b1;
                    bus.p0_rdata = r_rdata;
                    bus.p0_err   = r_err;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // last_gnt resets to port 1 so that port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_sel;
                        r_we    <= w_sel_we;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_err   <= w_oor;
                        r_rdata <= '0;
                    end
                end
                S_ACCESS: r_rdata    <= r_we ? '0 : bus.mem_read_data;
                S_RESP:   r_last_gnt <= r_gnt;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
